// File: rtl/clock_gating_model_pkg.sv
// rtl/clock_gating_model_pkg.sv - shared constants for the clock gating model
package clock_gating_model_pkg;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/clock_gating_model_cell.sv
// rtl/clock_gating_model_cell.sv - enable latch plus AND gate, replaceable by a library ICG
module clock_gate_cell (
    input  logic i_clk,
    input  logic i_en,
    output logic o_clk,
    output logic o_en_lat
);

    logic en_lat_q;

    // Transparent while the clock is low, so the gated high phase is always whole.
    always_latch begin
        if (!i_clk) begin
            en_lat_q <= i_en;
        end
    end

    assign o_clk    = i_clk & en_lat_q;
    assign o_en_lat = en_lat_q;

endmodule

// File: rtl/clock_gating_model.sv
// rtl/clock_gating_model.sv - glitch-free clock gate with status and delivered-pulse counter
module clock_gating_model
    import clock_gating_model_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clock_en,
    output logic             o_clk,
    output logic             o_clk_active,
    output logic [CNT_W-1:0] o_pulse_cnt
);

    logic             en_d;
    logic             en_lat;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Reset forces the enable low so the gate closes after the current high phase.
    always_comb begin
        en_d = i_clock_en & ~i_reset;
    end

    clock_gate_cell u_cell (
        .i_clk    (i_clk),
        .i_en     (en_d),
        .o_clk    (o_clk),
        .o_en_lat (en_lat)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (i_reset) begin
            cnt_d = '0;
        end else if (en_lat && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_clk_active = en_lat;
    assign o_pulse_cnt  = cnt_q;

endmodule

// File: tb/tb_clock_gating_model.sv
// tb/tb_clock_gating_model.sv - scoreboard bench for the clock gating model
`timescale 1ns/1ps
module tb_clock_gating_model;

    logic        clk;
    logic        rst;
    logic        en;
    logic        en4;
    logic        gclk;
    logic        act;
    logic [15:0] cnt;
    logic        gclk4;
    logic        act4;
    logic [3:0]  cnt4;

    int n_tests;
    int n_fail;
    int model_cnt;
    time rise_t;
    bit  mon_done;

    typedef struct {
        int          t;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    clock_gating_model #(.CNT_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clock_en   (en),
        .o_clk        (gclk),
        .o_clk_active (act),
        .o_pulse_cnt  (cnt)
    );

    clock_gating_model #(.CNT_W(4)) dut4 (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clock_en   (en4),
        .o_clk        (gclk4),
        .o_clk_active (act4),
        .o_pulse_cnt  (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int t, input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.t = t; e.sel = sel; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        if (time'(t) > $time) #(time'(t) - $time);
    endtask

    // Monitor: pops expectations in time order and compares against DUT outputs.
    initial begin
        exp_t        e;
        logic [15:0] act_v;
        mon_done = 1'b0;
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            wait_until(e.t);
            case (e.sel)
                0:       act_v = {15'd0, gclk};
                1:       act_v = {15'd0, act};
                2:       act_v = cnt;
                default: act_v = {12'd0, cnt4};
            endcase
            n_tests++;
            if (act_v !== e.exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got %0d expected %0d", e.name, $time, act_v, e.exp);
            end
        end
        mon_done = 1'b1;
    end

    // Pulse-width checker and independent edge count of the gated clock.
    always @(posedge gclk) begin
        rise_t = $time;
        model_cnt++;
    end

    always @(negedge gclk) begin
        n_tests++;
        if ($time - rise_t != 5) begin
            n_fail++;
            $display("FAIL pulse_width @%0t: got %0t expected 5", $time, $time - rise_t);
        end
    end

    always @(posedge clk) begin
        if (rst) model_cnt = 0;
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        model_cnt = 0;
        rise_t    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        en4       = 1'b0;

        push(50,  0, 0,  "reset_clk");
        push(50,  1, 0,  "reset_active");
        push(50,  2, 0,  "reset_cnt");
        push(101, 1, 1,  "en_low_phase_active");
        push(101, 0, 0,  "en_low_phase_clk");
        push(106, 0, 1,  "first_pulse_clk");
        push(106, 2, 1,  "first_pulse_cnt");
        push(196, 2, 10, "ten_pulses_cnt");
        push(201, 1, 0,  "disable_active");
        push(206, 0, 0,  "no_pulse_205");
        push(206, 2, 10, "cnt_hold_205");
        push(308, 0, 0,  "en_high_phase_no_runt");
        push(308, 1, 0,  "en_high_phase_active");
        push(311, 1, 1,  "en_latched_next_low");
        push(311, 0, 0,  "en_latched_clk_low");
        push(316, 0, 1,  "pulse_at_315");
        push(316, 2, 11, "cnt_at_315");
        push(408, 0, 1,  "reset_pulse_completes");
        push(408, 2, 20, "cnt_before_reset");
        push(411, 0, 0,  "reset_gate_closed");
        push(411, 1, 0,  "reset_active_low");
        push(416, 2, 0,  "reset_cnt_cleared");
        push(416, 0, 0,  "reset_no_pulse");
        push(436, 0, 1,  "post_reset_pulse");
        push(436, 2, 1,  "post_reset_cnt");
        push(506, 2, 7,  "post_reset_cnt_final");
        push(506, 0, 0,  "post_reset_clk_off");
        push(606, 3, 1,  "sat_cnt_1");
        push(736, 3, 14, "sat_cnt_14");
        push(746, 3, 15, "sat_cnt_15");
        push(756, 3, 15, "sat_hold_16");
        push(806, 3, 15, "sat_hold_20");

        wait_until(20);  rst = 1'b0;
        wait_until(100); en  = 1'b1;
        wait_until(200); en  = 1'b0;
        wait_until(307); en  = 1'b1;
        wait_until(407); rst = 1'b1;
        wait_until(430); rst = 1'b0;
        wait_until(500); en  = 1'b0;
        wait_until(600); en4 = 1'b1;
        wait_until(800); en4 = 1'b0;

        wait_until(1000);
        while ($time < 3000) begin
            int d;
            d = int'($urandom_range(1, 17));
            if (((int'($time) + d) % 10) == 5) d = d + 1;
            #(d);
            en = 1'(($urandom_range(0, 1)));
        end
        wait_until(3010); en = 1'b0;
        wait_until(3036);

        n_tests++;
        if (cnt !== model_cnt[15:0]) begin
            n_fail++;
            $display("FAIL random_cnt_vs_edges: got %0d expected %0d", cnt, model_cnt);
        end

        n_tests++;
        if (!mon_done) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
